// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32 x 64-bit register file: two requesters, per-beat
// round-robin with optional locked bursts, and a registered write port.
module regfile_wr_arbiter #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int MAX_BURST = 4,
    parameter int ZERO_REG  = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam logic [3:0]        BURST_CAP = 4'(MAX_BURST);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam bit                CAN_LOCK  = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ptr;
    logic [3:0]        r_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_acc;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_commit;
    logic              w_own_valid;
    logic [3:0]        w_cnt_inc;
    logic              w_cap_hit;

    // Grant decode: depends only on state, pointer, hold and valids; forced low in reset.
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        if (reset_n && !hold) begin
            case (r_state)
                IDLE: begin
                    w_rdy0 = req0_valid & (~req1_valid | ~r_ptr);
                    w_rdy1 = req1_valid & (~req0_valid |  r_ptr);
                end
                OWN0:    w_rdy0 = req0_valid;
                OWN1:    w_rdy1 = req1_valid;
                default: begin
                    w_rdy0 = 1'b0;
                    w_rdy1 = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready  = w_rdy0;
    assign req1_ready  = w_rdy1;

    assign w_acc       = w_rdy0 | w_rdy1;
    assign w_sel_lock  = w_rdy1 ? req1_lock : req0_lock;
    assign w_sel_addr  = w_rdy1 ? req1_addr : req0_addr;
    assign w_sel_data  = w_rdy1 ? req1_data : req0_data;
    assign w_commit    = w_acc && (w_sel_addr != ZERO_ADDR);
    assign w_own_valid = (r_state == OWN1) ? req1_valid : req0_valid;
    assign w_cnt_inc   = r_cnt + 4'd1;
    assign w_cap_hit   = (w_cnt_inc == BURST_CAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_cnt     <= 4'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // Zero-register beats are consumed but never reach the register file.
            r_wr_en <= w_commit;
            if (w_commit) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end

            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (w_sel_lock && CAN_LOCK) begin
                            r_state <= w_rdy1 ? OWN1 : OWN0;
                            r_cnt   <= 4'd1;
                        end else begin
                            r_ptr <= ~w_rdy1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    // Leave on unlocked beat, burst cap, or owner dropping valid while not held.
                    if (w_acc) begin
                        if (!w_sel_lock || w_cap_hit) begin
                            r_state <= IDLE;
                            r_cnt   <= 4'd0;
                            r_ptr   <= (r_state == OWN0);
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (!w_own_valid && !hold) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        r_ptr   <= (r_state == OWN0);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed-vector bench for regfile_wr_arbiter with hand-computed expectations.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        reset_n;
    logic        hold;
    logic        req0_valid, req0_lock, req0_ready;
    logic [4:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req1_valid, req1_lock, req1_ready;
    logic [4:0]  req1_addr;
    logic [63:0] req1_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy;

    int n_vec;
    int n_err;

    regfile_wr_arbiter #(
        .DATA_W(64), .ADDR_W(5), .MAX_BURST(4), .ZERO_REG(31)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_lock = 1'b0;
        req1_valid = 1'b0; req1_lock = 1'b0;
        hold = 1'b0;
    endtask

    task automatic rst_pulse();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [6:0] g_pat;
        logic [6:0] b_pat;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        idle_inputs();
        req0_addr = 5'd0; req0_data = 64'd0;
        req1_addr = 5'd0; req1_data = 64'd0;
        req0_valid = 1'b1;
        #3;
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("rst_hold_wr_en", {63'd0, wr_en}, 64'd0);
        reset_n = 1'b1;
        idle_inputs();

        // Single beat
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hA5A5;
        #1;
        chk("single_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("single_rdy1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("single_wr_en", {63'd0, wr_en}, 64'd1);
        chk("single_wr_addr", {59'd0, wr_addr}, 64'd5);
        chk("single_wr_data", wr_data, 64'hA5A5);
        req0_valid = 1'b0;
        tick();
        chk("single_wr_en_off", {63'd0, wr_en}, 64'd0);

        // Round robin from ptr=0
        rst_pulse();
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            req0_data = 64'h1100 + 64'(i);
            req1_data = 64'h2200 + 64'(i);
            #1;
            chk("rr_rdy0", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_rdy1", {63'd0, req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            chk("rr_wr_en", {63'd0, wr_en}, 64'd1);
            chk("rr_wr_addr", {59'd0, wr_addr}, (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_wr_data", wr_data, (i % 2 == 0) ? 64'h1100 + 64'(i) : 64'h2200 + 64'(i));
        end
        idle_inputs();

        // Locked burst cap of 4
        rst_pulse();
        g_pat = 7'b0010000;
        b_pat = 7'b1001110;
        req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 5'd3;
        req1_valid = 1'b1; req1_lock = 1'b0; req1_addr = 5'd4;
        for (int i = 0; i < 7; i++) begin
            req0_data = 64'h100 + 64'(i);
            req1_data = 64'h200 + 64'(i);
            #1;
            chk("burst_busy", {63'd0, busy}, {63'd0, b_pat[i]});
            chk("burst_rdy0", {63'd0, req0_ready}, {63'd0, ~g_pat[i]});
            chk("burst_rdy1", {63'd0, req1_ready}, {63'd0, g_pat[i]});
            tick();
            chk("burst_wr_addr", {59'd0, wr_addr}, g_pat[i] ? 64'd4 : 64'd3);
            chk("burst_wr_data", wr_data, g_pat[i] ? 64'h200 + 64'(i) : 64'h100 + 64'(i));
        end
        idle_inputs();
        tick();
        chk("burst_end_wr_en", {63'd0, wr_en}, 64'd0);
        chk("burst_end_busy", {63'd0, busy}, 64'd0);

        // Zero register (ptr=1 here)
        req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'hFFFF;
        #1;
        chk("zero_rdy1", {63'd0, req1_ready}, 64'd1);
        tick();
        chk("zero_wr_en", {63'd0, wr_en}, 64'd0);
        chk("zero_wr_addr", {59'd0, wr_addr}, 64'd3);
        chk("zero_wr_data", wr_data, 64'h106);
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 64'h800;
        req1_addr = 5'd9; req1_data = 64'h900;
        #1;
        chk("zero_ptr_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("zero_ptr_rdy1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("zero_next_wr_addr", {59'd0, wr_addr}, 64'd8);
        idle_inputs();

        // Hold and release (ptr=1 here)
        req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 5'd7; req0_data = 64'h700;
        #1;
        chk("hold_take_rdy0", {63'd0, req0_ready}, 64'd1);
        tick();
        chk("hold_take_wr_addr", {59'd0, wr_addr}, 64'd7);
        hold = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 64'h900;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_rdy0", {63'd0, req0_ready}, 64'd0);
            chk("hold_rdy1", {63'd0, req1_ready}, 64'd0);
            chk("hold_busy", {63'd0, busy}, 64'd1);
            tick();
            chk("hold_wr_en", {63'd0, wr_en}, 64'd0);
        end
        hold = 1'b0; req0_data = 64'h701;
        #1;
        chk("unhold_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("unhold_rdy1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("unhold_wr_data", wr_data, 64'h701);
        chk("unhold_busy", {63'd0, busy}, 64'd1);
        req0_valid = 1'b0;
        #1;
        chk("release_rdy1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("release_busy", {63'd0, busy}, 64'd0);
        req0_valid = 1'b1; req0_lock = 1'b0;
        #1;
        chk("after_rel_rdy1", {63'd0, req1_ready}, 64'd1);
        chk("after_rel_rdy0", {63'd0, req0_ready}, 64'd0);
        tick();
        chk("after_rel_wr_addr", {59'd0, wr_addr}, 64'd9);
        idle_inputs();

        // Reset in the middle of an OWN1 burst
        req1_valid = 1'b1; req1_lock = 1'b1; req1_addr = 5'd10; req1_data = 64'hA00;
        #1;
        chk("own1_rdy1", {63'd0, req1_ready}, 64'd1);
        tick();
        chk("own1_busy", {63'd0, busy}, 64'd1);
        req1_data = 64'hA01;
        tick();
        chk("own1_wr_en", {63'd0, wr_en}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_rdy1", {63'd0, req1_ready}, 64'd0);
        chk("midrst_wr_addr", {59'd0, wr_addr}, 64'd0);
        req0_valid = 1'b1; req0_lock = 1'b0; req0_addr = 5'd12; req0_data = 64'hC00;
        req1_lock = 1'b0;
        #1;
        chk("midrst_rdy0", {63'd0, req0_ready}, 64'd0);
        reset_n = 1'b1;
        #1;
        chk("postrst_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("postrst_rdy1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("postrst_wr_en", {63'd0, wr_en}, 64'd1);
        chk("postrst_wr_addr", {59'd0, wr_addr}, 64'd12);
        chk("postrst_wr_data", wr_data, 64'hC00);
        idle_inputs();
        tick();
        chk("final_wr_en", {63'd0, wr_en}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
